// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot iteration engine.
// Holds the default fixed-point geometry, the escape radius squared, the
// period-2 bulb radius squared and the engine FSM state encoding.
package mandel_pkg;

    localparam int unsigned FP_W_DEF   = 32;
    localparam int unsigned FRAC_DEF   = 24;
    localparam int unsigned ITER_W_DEF = 8;

    // 4.0 and 1/16 in the default Q8.24 format.
    localparam longint unsigned ESC_LIMIT = 64'(4) << FRAC_DEF;
    localparam longint unsigned BULB_R2   = 64'(1) << (FRAC_DEF - 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mandel_iter_core_sq_step.sv
// mandel_sq_step: one combinational Mandelbrot step.
// Given z and c it returns z^2 + c (truncated to FP_W) and |z|^2 (FP_W+2 bits).
// Ports:
//   z_re, z_im  in  current z
//   c_re, c_im  in  point c
//   nz_re, nz_im out next z
//   mag2        out zr^2 + zi^2 of the current z
module mandel_sq_step
    import mandel_pkg::*;
#(
    parameter int unsigned FP_W = FP_W_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic [FP_W-1:0] z_re,
    input  logic [FP_W-1:0] z_im,
    input  logic [FP_W-1:0] c_re,
    input  logic [FP_W-1:0] c_im,
    output logic [FP_W-1:0] nz_re,
    output logic [FP_W-1:0] nz_im,
    output logic [FP_W+1:0] mag2
);

    localparam int unsigned PW = 2 * FP_W;

    logic signed [PW-1:0] p_rr, p_ii, p_ri;
    logic signed [PW-1:0] s_rr, s_ii, s_ri;

    // Full-width signed products, then rescaled back to FRAC fractional bits.
    assign p_rr = PW'($signed(z_re)) * PW'($signed(z_re));
    assign p_ii = PW'($signed(z_im)) * PW'($signed(z_im));
    assign p_ri = PW'($signed(z_re)) * PW'($signed(z_im));

    assign s_rr = p_rr >>> FRAC;
    assign s_ii = p_ii >>> FRAC;
    // Doubling before the shift keeps the LSB of 2*zr*zi.
    assign s_ri = (p_ri <<< 1) >>> FRAC;

    assign mag2  = (FP_W+2)'(s_rr) + (FP_W+2)'(s_ii);
    assign nz_re = FP_W'(s_rr - s_ii) + c_re;
    assign nz_im = FP_W'(s_ri) + c_im;

endmodule

// File: rtl/mandel_iter_core.sv
// mandel_iter_core: per-pixel Mandelbrot escape-count engine.
// Accepts c and a pixel tag, iterates z <= z^2 + c once per clock from z = 0
// and returns the escape count (or max_iter) with the echoed tag.
// Optional build macro MANDEL_BULB_CHECK_EN short-circuits points inside the
// period-2 bulb (|c+1|^2 < 1/16) straight to a non-escaped result.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          input handshake (in_ready high only in IDLE)
//   in_c_re, in_c_im           c, signed fixed point with FRAC fraction bits
//   in_x, in_y                 pixel tag
//   max_iter                   iteration limit, sampled at accept
//   out_valid/out_ready        result handshake
//   out_iter, out_escaped      escape count and escape flag
//   out_x, out_y               echoed pixel tag
module mandel_iter_core
    import mandel_pkg::*;
#(
    parameter int unsigned FP_W   = FP_W_DEF,
    parameter int unsigned FRAC   = FRAC_DEF,
    parameter int unsigned ITER_W = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   in_c_re,
    input  logic [FP_W-1:0]   in_c_im,
    input  logic [10:0]       in_x,
    input  logic [9:0]        in_y,
    input  logic [ITER_W-1:0] max_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic [10:0]       out_x,
    output logic [9:0]        out_y
);

    localparam logic signed [FP_W+1:0] ESC_LIM = (FP_W+2)'(4) << FRAC;

    state_t            state, state_nxt;
    logic [FP_W-1:0]   zr, zr_nxt, zi, zi_nxt;
    logic [FP_W-1:0]   cr, cr_nxt, ci, ci_nxt;
    logic [ITER_W-1:0] n, n_nxt, lim, lim_nxt;
    logic [ITER_W-1:0] iter_nxt;
    logic              valid_nxt, esc_nxt;
    logic [10:0]       x_nxt;
    logic [9:0]        y_nxt;

    logic [FP_W-1:0]   step_re, step_im;
    logic [FP_W+1:0]   mag2;
    logic              escape;
    logic              in_bulb;

    mandel_sq_step #(.FP_W(FP_W), .FRAC(FRAC)) u_step (
        .z_re  (zr),
        .z_im  (zi),
        .c_re  (cr),
        .c_im  (ci),
        .nz_re (step_re),
        .nz_im (step_im),
        .mag2  (mag2)
    );

    // Strict compare: |z|^2 == 4.0 keeps iterating.
    assign escape = $signed(mag2) > ESC_LIM;

`ifdef MANDEL_BULB_CHECK_EN
    localparam int unsigned BW = FP_W + 1;
    localparam int unsigned SW = 2 * BW;
    localparam logic [BW-1:0]         ONE_B    = BW'(1) << FRAC;
    localparam logic signed [SW-1:0]  BULB_LIM = SW'(1) << (FRAC - 4);

    logic signed [BW-1:0] b_re, b_im;
    logic signed [SW-1:0] b_pre, b_pim, b_dist;

    // (cr+1)^2 + ci^2 at full width so large |c| cannot wrap into the bulb.
    assign b_re   = BW'($signed(in_c_re)) + $signed(ONE_B);
    assign b_im   = BW'($signed(in_c_im));
    assign b_pre  = SW'(b_re) * SW'(b_re);
    assign b_pim  = SW'(b_im) * SW'(b_im);
    assign b_dist = (b_pre >>> FRAC) + (b_pim >>> FRAC);
    assign in_bulb = b_dist < BULB_LIM;
`else
    assign in_bulb = 1'b0;
`endif

    assign in_ready = (state == IDLE);

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        zr_nxt    = zr;
        zi_nxt    = zi;
        cr_nxt    = cr;
        ci_nxt    = ci;
        n_nxt     = n;
        lim_nxt   = lim;
        valid_nxt = out_valid;
        iter_nxt  = out_iter;
        esc_nxt   = out_escaped;
        x_nxt     = out_x;
        y_nxt     = out_y;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    cr_nxt  = in_c_re;
                    ci_nxt  = in_c_im;
                    x_nxt   = in_x;
                    y_nxt   = in_y;
                    lim_nxt = max_iter;
                    zr_nxt  = '0;
                    zi_nxt  = '0;
                    n_nxt   = '0;
                    if (in_bulb) begin
                        state_nxt = DONE;
                        valid_nxt = 1'b1;
                        iter_nxt  = max_iter;
                        esc_nxt   = 1'b0;
                    end else begin
                        state_nxt = ITER;
                    end
                end
            end
            ITER: begin
                if (escape) begin
                    state_nxt = DONE;
                    valid_nxt = 1'b1;
                    iter_nxt  = n;
                    esc_nxt   = 1'b1;
                end else if (n == lim) begin
                    state_nxt = DONE;
                    valid_nxt = 1'b1;
                    iter_nxt  = lim;
                    esc_nxt   = 1'b0;
                end else begin
                    zr_nxt = step_re;
                    zi_nxt = step_im;
                    n_nxt  = n + ITER_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            zr          <= '0;
            zi          <= '0;
            cr          <= '0;
            ci          <= '0;
            n           <= '0;
            lim         <= '0;
            out_valid   <= 1'b0;
            out_iter    <= '0;
            out_escaped <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
        end else begin
            state       <= state_nxt;
            zr          <= zr_nxt;
            zi          <= zi_nxt;
            cr          <= cr_nxt;
            ci          <= ci_nxt;
            n           <= n_nxt;
            lim         <= lim_nxt;
            out_valid   <= valid_nxt;
            out_iter    <= iter_nxt;
            out_escaped <= esc_nxt;
            out_x       <= x_nxt;
            out_y       <= y_nxt;
        end
    end

endmodule

// File: tb/tb_mandel_iter_core.sv
// Directed bench for mandel_iter_core: hand-computed escape counts, latencies,
// tag echo, backpressure and mid-iteration reset.
// Honours MANDEL_BULB_CHECK_EN for the expected bulb-bypass latency.
module tb_mandel_iter_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_c_re, in_c_im;
    logic [10:0] in_x;
    logic [9:0]  in_y;
    logic [7:0]  max_iter;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_iter;
    logic        out_escaped;
    logic [10:0] out_x;
    logic [9:0]  out_y;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [31:0] ONE  = 32'h0100_0000;
    localparam logic [31:0] TWO  = 32'h0200_0000;
    localparam logic [31:0] MONE = 32'hFF00_0000;
    localparam logic [31:0] MTWO = 32'hFE00_0000;
    localparam logic [31:0] MHLF = 32'hFF80_0000;

    mandel_iter_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_c_re     (in_c_re),
        .in_c_im     (in_c_im),
        .in_x        (in_x),
        .in_y        (in_y),
        .max_iter    (max_iter),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_iter    (out_iter),
        .out_escaped (out_escaped),
        .out_x       (out_x),
        .out_y       (out_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one point for a single edge (E0) and return the number of edges
    // after E0 until out_valid is seen (-1 if it never shows up).
    task automatic send_point(input logic [31:0] cr, input logic [31:0] ci,
                              input logic [10:0] x, input logic [9:0] y,
                              input logic [7:0] mi, output int lat);
        @(negedge clk);
        in_c_re = cr; in_c_im = ci; in_x = x; in_y = y; max_iter = mi;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        if (out_valid) lat = 0;
        else begin
            for (int k = 1; k <= 400; k++) begin
                @(posedge clk); #1;
                if (out_valid) begin lat = k; break; end
            end
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_c_re = '0; in_c_im = '0; in_x = '0; in_y = '0; max_iter = '0;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vec_cnt++; if (out_iter !== 8'd0) begin err_cnt++; $display("FAIL rst_out_iter got %0d want 0", out_iter); end
        vec_cnt++; if (out_escaped !== 1'b0) begin err_cnt++; $display("FAIL rst_out_escaped got %b want 0", out_escaped); end
        vec_cnt++; if (out_x !== 11'd0 || out_y !== 10'd0) begin err_cnt++; $display("FAIL rst_tags got %0d,%0d want 0,0", out_x, out_y); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_c_zero();
        int lat;
        send_point(32'd0, 32'd0, 11'd5, 10'd6, 8'd255, lat);
        vec_cnt++; if (lat !== 256) begin err_cnt++; $display("FAIL c0_latency got %0d want 256", lat); end
        vec_cnt++; if (out_iter !== 8'd255 || out_escaped !== 1'b0) begin err_cnt++; $display("FAIL c0_result got %0d/%b want 255/0", out_iter, out_escaped); end
        take_result();
    endtask

    task automatic test_c_one();
        int lat;
        send_point(ONE, 32'd0, 11'd1234, 10'd567, 8'd100, lat);
        vec_cnt++; if (lat !== 4) begin err_cnt++; $display("FAIL c1_latency got %0d want 4", lat); end
        vec_cnt++; if (out_iter !== 8'd3 || out_escaped !== 1'b1) begin err_cnt++; $display("FAIL c1_result got %0d/%b want 3/1", out_iter, out_escaped); end
        vec_cnt++; if (out_x !== 11'd1234 || out_y !== 10'd567) begin err_cnt++; $display("FAIL c1_tags got %0d,%0d want 1234,567", out_x, out_y); end
        vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL c1_in_ready_done got %b want 0", in_ready); end
        take_result();
        vec_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin err_cnt++; $display("FAIL c1_after_hs got valid=%b ready=%b want 0,1", out_valid, in_ready); end
    endtask

    // |z|^2 == 4 exactly must not escape.
    task automatic test_boundary();
        int lat;
        send_point(TWO, 32'd0, 11'd2, 10'd2, 8'd50, lat);
        vec_cnt++; if (lat !== 3 || out_iter !== 8'd2 || out_escaped !== 1'b1) begin err_cnt++; $display("FAIL c2_result got lat=%0d %0d/%b want 3 2/1", lat, out_iter, out_escaped); end
        take_result();
        send_point(MTWO, 32'd0, 11'd3, 10'd3, 8'd20, lat);
        vec_cnt++; if (lat !== 21 || out_iter !== 8'd20 || out_escaped !== 1'b0) begin err_cnt++; $display("FAIL cm2_result got lat=%0d %0d/%b want 21 20/0", lat, out_iter, out_escaped); end
        take_result();
        send_point(32'd0, TWO, 11'd4, 10'd4, 8'd50, lat);
        vec_cnt++; if (lat !== 3 || out_iter !== 8'd2 || out_escaped !== 1'b1) begin err_cnt++; $display("FAIL c2i_result got lat=%0d %0d/%b want 3 2/1", lat, out_iter, out_escaped); end
        take_result();
    endtask

    // Imaginary and cross-term paths, plus a fractional bounded point.
    task automatic test_complex();
        int lat;
        send_point(32'd0, ONE, 11'd7, 10'd8, 8'd15, lat);
        vec_cnt++; if (lat !== 16 || out_iter !== 8'd15 || out_escaped !== 1'b0) begin err_cnt++; $display("FAIL ci_result got lat=%0d %0d/%b want 16 15/0", lat, out_iter, out_escaped); end
        take_result();
        send_point(ONE, ONE, 11'd9, 10'd10, 8'd50, lat);
        vec_cnt++; if (lat !== 3 || out_iter !== 8'd2 || out_escaped !== 1'b1) begin err_cnt++; $display("FAIL c1p1i_result got lat=%0d %0d/%b want 3 2/1", lat, out_iter, out_escaped); end
        take_result();
        send_point(MHLF, 32'd0, 11'd11, 10'd12, 8'd30, lat);
        vec_cnt++; if (lat !== 31 || out_iter !== 8'd30 || out_escaped !== 1'b0) begin err_cnt++; $display("FAIL cmhalf_result got lat=%0d %0d/%b want 31 30/0", lat, out_iter, out_escaped); end
        take_result();
    endtask

    task automatic test_bulb();
        int lat;
        int exp_lat;
`ifdef MANDEL_BULB_CHECK_EN
        exp_lat = 0;
`else
        exp_lat = 11;
`endif
        send_point(MONE, 32'd0, 11'd20, 10'd21, 8'd10, lat);
        vec_cnt++; if (lat !== exp_lat) begin err_cnt++; $display("FAIL bulb_latency got %0d want %0d", lat, exp_lat); end
        vec_cnt++; if (out_iter !== 8'd10 || out_escaped !== 1'b0) begin err_cnt++; $display("FAIL bulb_result got %0d/%b want 10/0", out_iter, out_escaped); end
        take_result();
    endtask

    task automatic test_max_zero();
        int lat;
        send_point(ONE, 32'd0, 11'd30, 10'd31, 8'd0, lat);
        vec_cnt++; if (lat !== 1 || out_iter !== 8'd0 || out_escaped !== 1'b0) begin err_cnt++; $display("FAIL max0_result got lat=%0d %0d/%b want 1 0/0", lat, out_iter, out_escaped); end
        take_result();
    endtask

    task automatic test_backpressure();
        int lat;
        int seen;
        send_point(ONE, 32'd0, 11'd77, 10'd33, 8'd50, lat);
        vec_cnt++; if (lat !== 4) begin err_cnt++; $display("FAIL bp_latency got %0d want 4", lat); end
        @(negedge clk);
        in_c_re = TWO; in_c_im = '0; in_x = 11'd99; in_y = 10'd99; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            vec_cnt++;
            if (out_valid !== 1'b1 || out_iter !== 8'd3 || out_escaped !== 1'b1 ||
                out_x !== 11'd77 || out_y !== 10'd33 || in_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL bp_hold cyc %0d got v=%b it=%0d e=%b x=%0d y=%0d rdy=%b want 1 3 1 77 33 0",
                         k, out_valid, out_iter, out_escaped, out_x, out_y, in_ready);
            end
        end
        @(negedge clk); in_valid = 1'b0;
        take_result();
        vec_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release got valid=%b ready=%b want 0,1", out_valid, in_ready); end
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
        vec_cnt++; if (seen !== 0) begin err_cnt++; $display("FAIL bp_no_accept got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_reset_mid();
        int seen;
        int lat;
        @(negedge clk);
        in_c_re = MTWO; in_c_im = '0; in_x = 11'd50; in_y = 10'd60; max_iter = 8'd200;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        vec_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_state got ready=%b valid=%b want 1,0", in_ready, out_valid); end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (250) begin @(posedge clk); #1; if (out_valid) seen++; end
        vec_cnt++; if (seen !== 0) begin err_cnt++; $display("FAIL midrst_stale got %0d valid cycles want 0", seen); end
        send_point(ONE, 32'd0, 11'd8, 10'd9, 8'd100, lat);
        vec_cnt++; if (lat !== 4 || out_iter !== 8'd3 || out_x !== 11'd8 || out_y !== 10'd9) begin err_cnt++; $display("FAIL midrst_next got lat=%0d it=%0d x=%0d y=%0d want 4 3 8 9", lat, out_iter, out_x, out_y); end
        take_result();
    endtask

    initial begin
        test_reset();
        test_c_zero();
        test_c_one();
        test_boundary();
        test_complex();
        test_bulb();
        test_max_zero();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
